example_fetch_queue: RTL

//  Instruction fetch front end sitting directly upstream of the text memory.
//  - Owns the fetch PC and drives the word address into the combinational-read text memory.
//  - Captures the returned instruction word together with its PC into a small prefetch FIFO.
//  - Presents the FIFO head to decode over a valid/ready handshake.
//  - Branch/jump redirects flush the FIFO and restart fetch at the target.

---
 rtl/example_fetch_queue_if.sv | 24 ++
 rtl/example_fetch_queue.sv | 89 ++++++++
 2 files changed

// File: rtl/example_fetch_queue_if.sv
// Fetch-queue bus: text-memory address/data, redirect request and the decode handshake.
// The master modport is the fetch queue; the slave modport is memory plus decode.
interface example_fetch_queue_if #(
  parameter int TEXT_BITS = 16
);
  logic [TEXT_BITS-3:0] text_address;
  logic [31:0]          text_q;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [31:0]          inst;
  logic [31:0]          inst_pc;

  modport master (
    output text_address, inst_valid, inst, inst_pc,
    input  text_q, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  text_address, inst_valid, inst, inst_pc,
    output text_q, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/example_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, reads the combinational text memory
// and buffers {pc, inst} pairs in a small FIFO that feeds decode; redirects flush and restart.
module example_fetch_queue #(
  parameter int          TEXT_BITS = 16,
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          DEPTH     = 4
) (
  input logic                  clock,
  input logic                  reset,
  example_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_pc_d   [DEPTH];
  logic [31:0]      mem_inst_q [DEPTH];
  logic [31:0]      mem_inst_d [DEPTH];

  logic pop;
  logic push;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign bus.text_address = fetch_pc_q[TEXT_BITS-1:2];
  assign bus.inst_valid   = (count_q != '0);
  assign bus.inst         = mem_inst_q[rd_ptr_q];
  assign bus.inst_pc      = mem_pc_q[rd_ptr_q];

  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign pop  = bus.inst_valid & bus.inst_ready & ~bus.redirect_valid;
  assign push = ~bus.redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]   = fetch_pc_q;
        mem_inst_d[wr_ptr_q] = bus.text_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        fetch_pc_d           = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
    end
  end
endmodule
